// File: rtl/mips_pkg.sv
// Shared constants and FSM state encoding for the register-file dump reader.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    PRESENT,
    CSUM,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file over an asynchronous read port and streams each word out on valid/ready.
// Optional trailing XOR checksum word when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  dump_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] index_reg;
  logic              last_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_reg;
`endif

  logic handshake;
  logic final_word;

  assign handshake  = out_valid && out_ready;
  assign final_word = (cnt_reg == ADDR_W'(LAST_REG));

  // The counter only moves on start or a handshake, so it doubles as a stable read address.
  assign rf_rd_addr = cnt_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign out_valid  = (state_reg == PRESENT) || (state_reg == CSUM);
  assign out_data   = data_reg;
  assign out_index  = index_reg;
  assign out_last   = last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = PRESENT;
      PRESENT: begin
        if (handshake) begin
          if (final_word) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = READ;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CSUM:    if (handshake) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      data_reg  <= '0;
      index_reg <= '0;
      last_reg  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else if (abort) begin
      last_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg <= ADDR_W'(FIRST_REG);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_reg <= '0;
`endif
          end
        end
        READ: begin
          data_reg  <= rf_rd_data;
          index_reg <= cnt_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          last_reg  <= 1'b0;
`else
          last_reg  <= final_word;
`endif
        end
        PRESENT: begin
          if (handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_reg <= csum_reg ^ data_reg;
            // Checksum word is loaded straight into the output registers for the CSUM beat.
            if (final_word) begin
              data_reg  <= csum_reg ^ data_reg;
              index_reg <= '0;
              last_reg  <= 1'b1;
            end
`endif
            if (!final_word) cnt_reg <= cnt_reg + ADDR_W'(1);
          end
        end
        DONE:    last_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader against a behavioural 32x32 register file.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  word_t       sb[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr];

  regfile_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 32; i++) begin
      sb.push_back('{idx: 5'(i), data: exp_rf[i], last: (i == 31) && !CSUM_EN});
      x ^= exp_rf[i];
    end
    if (CSUM_EN) sb.push_back('{idx: 5'd0, data: x, last: 1'b1});
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      rf[i]     = 32'hA5A50000 + 32'(i);
      exp_rf[i] = 32'hA5A50000 + 32'(i);
    end
  endtask

  // Monitor: pop on each accepted word, and watch that a stalled word holds still.
  word_t held;
  bit    hold_valid = 1'b0;
  always @(negedge clk) begin
    word_t got, want;
    got = '{idx: out_index, data: out_data, last: out_last};
    if (!rst && !abort && hold_valid && out_valid) check("stall_stable", 64'(got), 64'(held));
    if (!rst && !abort && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        want = sb.pop_front();
        check("word", 64'(got), 64'(want));
      end
    end
    hold_valid <= !rst && !abort && out_valid && !out_ready;
    held       <= got;
  end

  initial begin
    int cycles;
    bit found;

    preload();

    // Reset state
    step(); step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_addr", 64'(rf_rd_addr), 64'd0);
    rst = 1'b0;
    step();

    // 1: full dump with ready held high, latency start->done
    push_dump();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 1;
    check("s1_busy_after_start", 64'(busy), 64'd1);
    while (!done && cycles < 200) begin
      step();
      cycles++;
    end
    check("s1_cycles", 64'(cycles), CSUM_EN ? 64'd66 : 64'd65);
    check("s1_sb_drained", 64'(sb.size()), 64'd0);
    step();
    check("s1_done_pulse", 64'(done), 64'd0);
    check("s1_idle", 64'(busy), 64'd0);

    // 2: random backpressure, roughly 30% ready
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      out_ready = ($urandom_range(0, 9) < 3);
      step();
      cycles++;
    end
    check("s2_done", 64'(done), 64'd1);
    check("s2_sb_drained", 64'(sb.size()), 64'd0);
    out_ready = 1'b1;
    step();

    // 3: abort while presenting index 10
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_index == 5'd10) begin
        out_ready = 1'b0;
        abort = 1'b1;
        found = 1'b1;
      end else begin
        step();
      end
    end
    check("s3_reached_idx10", 64'(found), 64'd1);
    step();
    abort = 1'b0;
    out_ready = 1'b1;
    check("s3_valid", 64'(out_valid), 64'd0);
    check("s3_busy", 64'(busy), 64'd0);
    check("s3_last", 64'(out_last), 64'd0);
    check("s3_remaining", 64'(sb.size()), CSUM_EN ? 64'd23 : 64'd22);
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      check("s3_no_done", 64'(done), 64'd0);
      step();
    end

    // 3b: fresh dump after abort restarts from index 0
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      step();
      cycles++;
    end
    check("s3b_done", 64'(done), 64'd1);
    check("s3b_sb_drained", 64'(sb.size()), 64'd0);
    step();

    // 4: reset during index 5 with a handshake in the same cycle
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_index == 5'd5) begin
        rst = 1'b1;
        found = 1'b1;
      end else begin
        step();
      end
    end
    check("s4_reached_idx5", 64'(found), 64'd1);
    step();
    check("s4_busy", 64'(busy), 64'd0);
    check("s4_done", 64'(done), 64'd0);
    check("s4_valid", 64'(out_valid), 64'd0);
    check("s4_last", 64'(out_last), 64'd0);
    check("s4_data", 64'(out_data), 64'd0);
    check("s4_index", 64'(out_index), 64'd0);
    check("s4_addr", 64'(rf_rd_addr), 64'd0);
    rst = 1'b0;
    check("s4_remaining", 64'(sb.size()), CSUM_EN ? 64'd28 : 64'd27);
    sb.delete();
    step();

    // 5: writes during the dump; reg3 already captured, reg20 not yet read
    preload();
    exp_rf[20] = 32'h12345678;
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      if (out_valid && out_index == 5'd3) rf[3] = 32'hDEADBEEF;
      if (out_valid && out_index == 5'd10) rf[20] = 32'h12345678;
      step();
      cycles++;
    end
    check("s5_done", 64'(done), 64'd1);
    check("s5_sb_drained", 64'(sb.size()), 64'd0);

    // start during the DONE cycle is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_done_busy", 64'(busy), 64'd0);
    step();
    check("start_in_done_still_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader that walks the 32x32 register file over one of its asynchronous read ports.
- Streams each register's contents out on a valid/ready interface.
- Used for debug/scan-out of architectural state after a program halts, and by the testbench for end-of-run state comparison.
- Acts as the initiator/consumer on the register-file read port.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- FIRST_REG, 0, first register index dumped.
- LAST_REG, 31, last register index dumped; must be >= FIRST_REG.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a dump; sampled only in IDLE
- abort  input  1  cancel dump in progress; returns to IDLE next edge
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the final word handshakes
- rf_rd_addr  output  ADDR_W  address driven to the register-file read port
- rf_rd_data  input  DATA_W  combinational read data returned for rf_rd_addr
- out_valid  output  1  out_data/out_index/out_last hold a word
- out_ready  input  1  downstream accepts the word
- out_data  output  DATA_W  captured register contents
- out_index  output  ADDR_W  register index of out_data
- out_last  output  1  marks the final word of the dump

Behaviour:
- Clock and reset: single clock domain, reset is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, out_valid=0, out_last=0; out_data=0, out_index=0, rf_rd_addr=0.
- Reset asserted mid-dump: everything returns to reset values on that edge, with no done pulse.
- IDLE:
  - start=1 -> READ, with the address counter loaded to FIRST_REG.
  - start=0 -> stay in IDLE.
- READ (one cycle):
  - rf_rd_addr = counter.
  - At the edge, capture rf_rd_data into out_data and the counter into out_index.
  - Set out_last when counter==LAST_REG. Then go to PRESENT.
- PRESENT:
  - out_valid=1.
  - out_data, out_index and out_last stay stable until the handshake (out_valid && out_ready).
  - On handshake with out_last=0: increment counter, go to READ.
  - On handshake with out_last=1: go to DONE.
- DONE (one cycle): done=1, then IDLE.
- Outside READ, rf_rd_addr holds its last value; it does not toggle.
- Throughput and latency:
  - Throughput is 1 word per 2 cycles with out_ready held high.
  - First out_valid appears 2 cycles after start is sampled.
- abort has priority over every transition except rst:
  - Next state is IDLE; out_valid and out_last drop.
  - No done pulse.
  - An abort that coincides with a handshake still aborts.
- start while busy is ignored.
- start asserted in the DONE cycle is ignored; a new dump needs start in IDLE.
- Counter arithmetic is ADDR_W bits. It never wraps because the dump terminates at LAST_REG.
- FIRST_REG==LAST_REG gives a single-word dump with out_last=1 on that word.
- Register-file writes during a dump are not blocked; the snapshot is not atomic:
  - An already-captured register reflects its old value.
  - A not-yet-read register reflects its new value.
- Register 0 is dumped as whatever the register file returns; no forcing to zero.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined:
  - After the final register handshakes, enter state CSUM and present one extra word.
  - out_data = XOR of all dumped words; out_index = 0; out_last = 1.
  - For the final register word, out_last = 0.
  - DONE follows the CSUM handshake.
  - The accumulator clears on start and folds each word at its handshake.
  - abort in CSUM behaves as in PRESENT.
- Undefined: no CSUM state, no accumulator logic; behaviour exactly as above.

Decomposition:
- Shared package (mips_pkg) holds:
  - the state enum (IDLE, READ, PRESENT, CSUM, DONE);
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 constants.
- No sub-module needed. The FSM plus counter and capture registers form one module.
- The testbench pairs it with the existing register file.

Test Plan:
1. Preload reg[i]=32'hA5A50000+i; pulse start with out_ready=1 -> 32 words, index 0..31, data A5A50000..A5A5001F, out_last only on index 31, done pulses 1 cycle later, total 65 cycles from start to done.
2. Random out_ready backpressure (30% high) -> out_data/out_index stable while valid && !ready, and no word dropped or duplicated.
3. abort while presenting index 10 -> IDLE next cycle, out_valid=0, no done; a following start re-dumps from index 0.
4. Assert rst during index 5 with a handshake in the same cycle -> all outputs at reset values next cycle, busy=0.
5. Write reg[3]=32'hDEADBEEF after index 3 is captured and reg[20]=32'h12345678 before index 20 -> dumped index 3 shows the old value, index 20 shows 32'h12345678.
6. With REGFILE_DUMP_CHECKSUM_EN defined and the preload of scenario 1 -> 33rd word = 32'h00000000 (XOR of 32 identical upper halves plus 0..31 = 0) with out_last=1, and index 31 has out_last=0.
